step_ctrl: RTL and testbench

Control front-end for the LED rotator: turns raw push-button levels into clean control for the shift stage. It debounces the enable and direction buttons and converts each press into a toggle of `en` and `dir`. It also replaces the derived divided clock with a single-cycle `step` strobe on the system clock, so the rotator runs with `step` as a clock enable.

---
 rtl/step_ctrl_pkg.sv | 14 +
 rtl/btn_debounce.sv | 60 ++++++
 rtl/step_ctrl.sv | 103 ++++++++++
 tb/tb_step_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types and reset constants for the LED rotator control front-end.
package step_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic EN_RST  = 1'b0;
  localparam logic DIR_RST = 1'b1;

  typedef logic [1:0] spd_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, level debounce over DB_CYCLES, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync_q, sync_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    sync1_d      = btn;
    sync_d       = sync1_q;
    stable_d     = stable_q;
    db_cnt_d     = '0;
    stable_dly_d = stable_q;
    // Pulse is taken from the registered level so it trails stable by one cycle.
    press_d      = stable_q & ~stable_dly_q;
    if (sync_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync_q       <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync_q       <= sync_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/step_ctrl.sv
// Rotator control: debounced en/dir toggles and a one-cycle step strobe every DIV cycles in RUN.
// Optional STEP_CTRL_SPEED_EN adds btn_spd/spd, dividing the step period by 2^spd.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DIV       = 33554432,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_en,
  input  logic       btn_dir,
`ifdef STEP_CTRL_SPEED_EN
  input  logic       btn_spd,
  output logic [1:0] spd,
`endif
  output logic       en,
  output logic       dir,
  output logic       step
);

  localparam int unsigned CW = $clog2(DIV);

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] pre_cnt_q, pre_cnt_d;
  logic [CW-1:0] tc;
  logic          hit;
  logic          en_press, dir_press;
  logic          en_stable_unused, dir_stable_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_en_db (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_en),
    .stable (en_stable_unused),
    .press  (en_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dir_db (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_dir),
    .stable (dir_stable_unused),
    .press  (dir_press)
  );

`ifdef STEP_CTRL_SPEED_EN
  spd_t spd_q, spd_d;
  logic spd_press, spd_stable_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_spd_db (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_spd),
    .stable (spd_stable_unused),
    .press  (spd_press)
  );

  always_comb spd_d = spd_q + spd_t'(spd_press);

  always_ff @(posedge clk) begin
    if (rst) spd_q <= '0;
    else     spd_q <= spd_d;
  end

  assign tc  = CW'((DIV >> spd_q) - 1);
  assign spd = spd_q;
`else
  assign tc = CW'(DIV - 1);
`endif

  assign hit = (state_q == ST_RUN) && (pre_cnt_q == tc);

  always_comb begin
    state_d = state_q;
    if (en_press) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    dir_d = dir_q ^ dir_press;
    // Counter only moves while running; STOP parks it at zero for a clean restart.
    pre_cnt_d = '0;
    if ((state_q == ST_RUN) && !hit) pre_cnt_d = pre_cnt_q + CW'(1);
`ifdef STEP_CTRL_SPEED_EN
    if (spd_press) pre_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= state_t'(EN_RST);
      dir_q     <= DIR_RST;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign en   = (state_q == ST_RUN);
  assign dir  = dir_q;
  assign step = hit;

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl with DIV=8, DB_CYCLES=4 against an event-level reference model.
module tb_step_ctrl;

  localparam int DIV = 8;
  localparam int DB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_en = 1'b0;
  logic btn_dir = 1'b0;
  logic en, dir, step;
`ifdef STEP_CTRL_SPEED_EN
  logic       btn_spd = 1'b0;
  logic [1:0] spd;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int run_start = 0;

  // Reference model: a raw level held DB samples is accepted; a 0->1 acceptance
  // toggles the output 4 edges later. Steps fall at DIV-1 mod DIV after en rises.
  logic exp_en = 1'b0, exp_dir = 1'b1, exp_step = 1'b0;
  logic acc_e = 1'b0, acc_d = 1'b0;
  int   run_e = 0, run_d = 0;
  int   pend_e[$];
  int   pend_d[$];

  step_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_en  (btn_en),
    .btn_dir (btn_dir),
`ifdef STEP_CTRL_SPEED_EN
    .btn_spd (btn_spd),
    .spd     (spd),
`endif
    .en      (en),
    .dir     (dir),
    .step    (step)
  );

  always #5 clk = ~clk;

  function automatic bit deb(input logic raw, inout logic acc, inout int run);
    if (raw != acc) begin
      run++;
      if (run == DB) begin
        acc = raw;
        run = 0;
        return raw;
      end
    end else begin
      run = 0;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_en = 1'b0; exp_dir = 1'b1;
      acc_e = 1'b0; acc_d = 1'b0; run_e = 0; run_d = 0;
      pend_e.delete(); pend_d.delete();
    end else begin
      if (deb(btn_en, acc_e, run_e))  pend_e.push_back(cyc + 4);
      if (deb(btn_dir, acc_d, run_d)) pend_d.push_back(cyc + 4);
      if (pend_e.size() > 0 && pend_e[0] == cyc) begin
        void'(pend_e.pop_front());
        exp_en = ~exp_en;
        if (exp_en) run_start = cyc;
      end
      if (pend_d.size() > 0 && pend_d[0] == cyc) begin
        void'(pend_d.pop_front());
        exp_dir = ~exp_dir;
      end
    end
    exp_step = exp_en && (((cyc - run_start) % DIV) == DIV - 1);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic d);
    rst = r; btn_en = e; btn_dir = d;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 103; i++) begin
      drive(i < 3, 1'b0, 1'b0);
      checks++;
      if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
        failures++;
        $display("FAIL reset cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", cyc, en, dir, step, exp_en, exp_dir, exp_step);
      end
    end
  endtask

  task automatic test_start();
    int k, rise, first, last, bad;
    k = cyc + 1; rise = -1; first = -1; last = -1; bad = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, i < 10, 1'b0);
      checks++;
      if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
        failures++;
        $display("FAIL start cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", cyc, en, dir, step, exp_en, exp_dir, exp_step);
      end
      if (en === 1'b1 && rise < 0) rise = cyc;
      if (step === 1'b1) begin
        if (first < 0) first = cyc;
        else if (cyc - last != DIV) bad++;
        last = cyc;
      end
    end
    checks++;
    if (rise !== k + 3 + DB) begin
      failures++;
      $display("FAIL start_en_rise got=%0d want=%0d", rise, k + 3 + DB);
    end
    checks++;
    if (first - rise !== DIV - 1) begin
      failures++;
      $display("FAIL start_first_step got_gap=%0d want=%0d", first - rise, DIV - 1);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL start_period bad_gaps=%0d want=0", bad);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int presses;
    pat = 8'b1110_1101;
    presses = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, (i < 8) ? pat[i] : 1'b0, 1'b0);
      if (dut.u_en_db.press === 1'b1) presses++;
      checks++;
      if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
        failures++;
        $display("FAIL bounce cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", cyc, en, dir, step, exp_en, exp_dir, exp_step);
      end
    end
    checks++;
    if (presses !== 0 || en !== 1'b1) begin
      failures++;
      $display("FAIL bounce_press got_presses=%0d en=%b want_presses=0 en=1", presses, en);
    end
  endtask

  task automatic test_dir_running();
    int last, bad;
    last = -1; bad = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b0, i < 8);
      checks++;
      if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
        failures++;
        $display("FAIL dir_run cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", cyc, en, dir, step, exp_en, exp_dir, exp_step);
      end
      if (step === 1'b1) begin
        if (last >= 0 && cyc - last != DIV) bad++;
        last = cyc;
      end
    end
    checks++;
    if (dir !== 1'b0 || bad !== 0) begin
      failures++;
      $display("FAIL dir_run_final got_dir=%b bad_gaps=%0d want_dir=0 bad_gaps=0", dir, bad);
    end
  endtask

  task automatic test_stop_resume();
    int ce, cd;
    for (int ph = 0; ph < 3; ph++) begin
      ce = -1; cd = -1;
      for (int i = 0; i < 40; i++) begin
        logic pe, pd;
        pe = en; pd = dir;
        drive(1'b0, i < 8, (ph == 2) && (i < 8));
        checks++;
        if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
          failures++;
          $display("FAIL stop_resume ph=%0d cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", ph, cyc, en, dir, step, exp_en, exp_dir, exp_step);
        end
        if (en !== pe) ce = cyc;
        if (dir !== pd) cd = cyc;
      end
      checks++;
      if (en !== ph[0]) begin
        failures++;
        $display("FAIL stop_resume_en ph=%0d got=%b want=%b", ph, en, ph[0]);
      end
    end
    checks++;
    if (ce < 0 || ce !== cd) begin
      failures++;
      $display("FAIL simultaneous en_cyc=%0d dir_cyc=%0d want equal", ce, cd);
    end
  endtask

  task automatic test_reset_mid_press();
    int p, rise;
    p = 0; rise = -1;
    for (int i = 0; i < 50; i++) begin
      if (i == 6) p = cyc;
      drive(i == 4 || i == 5, i < 18, 1'b0);
      checks++;
      if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", cyc, en, dir, step, exp_en, exp_dir, exp_step);
      end
      if (i >= 6 && en === 1'b1 && rise < 0) rise = cyc;
    end
    checks++;
    if (rise !== p + 4 + DB) begin
      failures++;
      $display("FAIL reset_mid_rise got=%0d want=%0d", rise, p + 4 + DB);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int mask, len, gap;
      mask = $urandom_range(1, 3);
      len  = $urandom_range(1, 8);
      gap  = $urandom_range(10, 16);
      for (int i = 0; i < len + gap; i++) begin
        drive(1'b0, mask[0] && (i < len), mask[1] && (i < len));
        checks++;
        if ({en, dir, step} !== {exp_en, exp_dir, exp_step}) begin
          failures++;
          $display("FAIL random n=%0d cyc=%0d en/dir/step got=%b%b%b want=%b%b%b", n, cyc, en, dir, step, exp_en, exp_dir, exp_step);
        end
      end
    end
  endtask

`ifdef STEP_CTRL_SPEED_EN
  task automatic test_speed();
    if (!exp_en) begin
      for (int i = 0; i < 20; i++) drive(1'b0, i < 8, 1'b0);
    end
    for (int s = 1; s <= 4; s++) begin
      int last, gap;
      last = -1; gap = -1;
      for (int i = 0; i < 28; i++) begin
        btn_spd = (i < 8);
        drive(1'b0, 1'b0, 1'b0);
      end
      btn_spd = 1'b0;
      for (int i = 0; i < 20; i++) begin
        drive(1'b0, 1'b0, 1'b0);
        if (step === 1'b1) begin
          if (last >= 0) gap = cyc - last;
          last = cyc;
        end
      end
      checks++;
      if (spd !== 2'(s % 4) || gap !== (DIV >> (s % 4))) begin
        failures++;
        $display("FAIL speed s=%0d got_spd=%0d period=%0d want_spd=%0d period=%0d", s, spd, gap, s % 4, DIV >> (s % 4));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_dir_running();
    test_stop_resume();
    test_reset_mid_press();
    test_random();
`ifdef STEP_CTRL_SPEED_EN
    test_speed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
